// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and digit constants for the stopwatch core
package stopwatch_pkg;

  localparam int DIGIT_W      = 4;
  localparam int NUM_DIGITS   = 5;
  localparam int BCD_MAX      = 9;
  localparam int SEC_TENS_MAX = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  function automatic logic is_counting(input state_e st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one BCD digit with wrap at MAX and combinational carry out
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = BCD_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  // Carry is qualified by en so the next digit only advances on a counted tick.
  assign carry = en && (digit_q == MAX_D);
  assign digit = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (en) begin
      digit_d = carry ? '0 : digit_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - MM:SS.t stopwatch: run/pause/lap FSM, BCD digit chain, display mux
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MIN_TENS_MAX = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic                          start_stop,
  input  logic                          clear,
  input  logic                          lap,
  output logic [NUM_DIGITS*DIGIT_W-1:0] disp_bcd,
  output logic                          running,
  output logic                          lap_active,
  output logic                          rollover
);

  localparam int BUS_W = NUM_DIGITS * DIGIT_W;

  state_e           state_q;
  state_e           state_d;
  logic [BUS_W-1:0] lap_q;
  logic [BUS_W-1:0] lap_d;
  logic             rollover_q;

  logic [DIGIT_W-1:0] tenths, sec_ones, sec_tens, min_ones, min_tens;
  logic               c_tenths, c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;
  logic               count_en;
  logic [BUS_W-1:0]   live_count;

  // Counting follows the pre-edge state, so a start coincident with a tick is not counted.
  assign count_en   = tick && is_counting(state_q) && !clear;
  assign live_count = {min_tens, min_ones, sec_tens, sec_ones, tenths};

  bcd_digit_counter #(.MAX(BCD_MAX)) u_tenths (
    .clk(clk), .rst_n(rst_n), .en(count_en), .clr(clear),
    .digit(tenths), .carry(c_tenths)
  );

  bcd_digit_counter #(.MAX(BCD_MAX)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .en(c_tenths), .clr(clear),
    .digit(sec_ones), .carry(c_sec_ones)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .en(c_sec_ones), .clr(clear),
    .digit(sec_tens), .carry(c_sec_tens)
  );

  bcd_digit_counter #(.MAX(BCD_MAX)) u_min_ones (
    .clk(clk), .rst_n(rst_n), .en(c_sec_tens), .clr(clear),
    .digit(min_ones), .carry(c_min_ones)
  );

  bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .en(c_min_ones), .clr(clear),
    .digit(min_tens), .carry(c_min_tens)
  );

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    if (clear) begin
      state_d = ST_IDLE;
      lap_d   = '0;
    end else if (start_stop) begin
      case (state_q)
        ST_IDLE, ST_PAUSE: state_d = ST_RUN;
        ST_RUN, ST_LAP:    state_d = ST_PAUSE;
        default:           state_d = ST_IDLE;
      endcase
    end else if (lap) begin
      // Lap captures the registered count, i.e. the value before any same-cycle tick.
      if (state_q == ST_RUN) begin
        state_d = ST_LAP;
        lap_d   = live_count;
      end else if (state_q == ST_LAP) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lap_q      <= '0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lap_q      <= lap_d;
      rollover_q <= c_min_tens;
    end
  end

  assign disp_bcd   = (state_q == ST_LAP) ? lap_q : live_count;
  assign running    = is_counting(state_q);
  assign lap_active = (state_q == ST_LAP);
  assign rollover   = rollover_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - directed self-checking bench for stopwatch_core
module tb_stopwatch_core;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [19:0] disp_bcd;
  logic        running;
  logic        lap_active;
  logic        rollover;

  int n_cmp = 0;
  int n_err = 0;

  stopwatch_core #(.MIN_TENS_MAX(5)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .disp_bcd(disp_bcd), .running(running),
    .lap_active(lap_active), .rollover(rollover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t, input logic ss, input logic cl, input logic lp);
    tick = t; start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    #1;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    // Reset held with ticks and a start pulse applied
    @(posedge clk); #1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(3);
    chk("rst_disp", 32'(disp_bcd), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_lap_active", 32'(lap_active), 32'h0);
    chk("rst_rollover", 32'(rollover), 32'h0);
    rst_n = 1'b1;
    ticks(2);
    chk("idle_no_count", 32'(disp_bcd), 32'h0);

    // Basic count
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(15);
    chk("basic_disp", 32'(disp_bcd), 32'h00015);
    chk("basic_running", 32'(running), 32'h1);

    // Pause / resume
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear_disp", 32'(disp_bcd), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    chk("pr_run3", 32'(disp_bcd), 32'h00003);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    chk("pr_paused", 32'(disp_bcd), 32'h00003);
    chk("pr_paused_running", 32'(running), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("pr_lap_ignored", 32'(lap_active), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    chk("pr_resumed", 32'(disp_bcd), 32'h00005);

    // Lap freeze and release
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(20);
    chk("lap_pre", 32'(disp_bcd), 32'h00020);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("lap_frozen0", 32'(disp_bcd), 32'h00020);
    ticks(29);
    chk("lap_frozen", 32'(disp_bcd), 32'h00020);
    chk("lap_active", 32'(lap_active), 32'h1);
    chk("lap_running", 32'(running), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lap_release", 32'(disp_bcd), 32'h00050);
    chk("lap_release_flag", 32'(lap_active), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(4);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lap_stop_live", 32'(disp_bcd), 32'h00054);
    chk("lap_stop_state", 32'({running, lap_active}), 32'h0);

    // Wrap at 59:59.9
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(35999);
    chk("wrap_max", 32'(disp_bcd), 32'h59599);
    chk("wrap_no_roll_early", 32'(rollover), 32'h0);
    ticks(1);
    chk("wrap_zero", 32'(disp_bcd), 32'h0);
    chk("wrap_rollover", 32'(rollover), 32'h1);
    chk("wrap_running", 32'(running), 32'h1);
    ticks(1);
    chk("wrap_roll_pulse", 32'(rollover), 32'h0);
    chk("wrap_continue", 32'(disp_bcd), 32'h00001);

    // Simultaneous inputs
    ticks(1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("sim_clear_disp", 32'(disp_bcd), 32'h0);
    chk("sim_clear_running", 32'(running), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sim_start_disp", 32'(disp_bcd), 32'h0);
    chk("sim_start_running", 32'(running), 32'h1);
    ticks(1);
    chk("sim_first_tick", 32'(disp_bcd), 32'h00001);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sim_stop_counted", 32'(disp_bcd), 32'h00002);
    chk("sim_stop_running", 32'(running), 32'h0);

    // Async reset mid-count
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_disp", 32'(disp_bcd), 32'h0);
    chk("async_rst_state", 32'({running, rollover}), 32'h0);
    rst_n = 1'b1;
    ticks(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
